// File: rtl/async_fifo_pkg.sv
// Shared defaults for the async_fifo block: default word width and depth,
// plus the helper deriving the pointer address width from the depth.
package async_fifo_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 16;

  // Address bits needed to index a DEPTH-word array (DEPTH is a power of two).
  function automatic int unsigned calc_ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Storage array for async_fifo: one synchronous write port and one
// registered read port. Only the read register is reset; the array is not.
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = calc_ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word at the write address when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: capture the addressed word on an accepted read, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO of DEPTH words of WIDTH bits with full/empty flags.
// Pointers carry an extra wrap bit to distinguish full from empty.
// Optional macro ASYNC_FIFO_ERR_EN enables the registered wr_err/rd_err
// pulses; without it both outputs are tied low and rejected requests are
// dropped silently.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned PTR_WIDTH = calc_ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             wr_err,
  output logic             rd_err
);

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [PTR_WIDTH:0] wr_ptr;
  logic [PTR_WIDTH:0] rd_ptr;
  logic               wr_ok;
  logic               rd_ok;

  // Status flags straight from the pointer registers.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
            (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
  end

  // Each side is qualified against the flags as they stand before the edge.
  always_comb begin
    wr_ok = wr_en && !full;
    rd_ok = rd_en && !empty;
  end

  // Pointer registers: advance on accepted requests, wrap bit included.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  async_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr[PTR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rd_ptr[PTR_WIDTH-1:0]),
    .rdata (rdata)
  );

`ifdef ASYNC_FIFO_ERR_EN
  // Error pulses: high for the single cycle after a rejected request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wr_err <= wr_en && full;
      rd_err <= rd_en && empty;
    end
  end
`else
  // Error reporting disabled: outputs held low.
  always_comb begin
    wr_err = 1'b0;
    rd_err = 1'b0;
  end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo (DEPTH=16, WIDTH=8).
module tb_async_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

`ifdef ASYNC_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             wr_err;
  logic             rd_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  async_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wdata  (wdata),
    .rd_en  (rd_en),
    .rdata  (rdata),
    .full   (full),
    .empty  (empty),
    .wr_err (wr_err),
    .rd_err (rd_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Distinct non-zero test words per sequence.
  function automatic logic [7:0] word(input int unsigned seed, input int unsigned i);
    logic [31:0] v;
    v = seed + 37 * i;
    return v[7:0];
  endfunction

  // One clock: drive inputs, take the edge, settle 1ns, release requests.
  task automatic tick(input logic w, input logic [7:0] wd, input logic r);
    wr_en = w;
    wdata = wd;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    tick(1'b0, 8'h00, 1'b0);

    // Reset then idle
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_wr_err", wr_err, 0);
    check_eq("rst_rd_err", rd_err, 0);

    // Read on empty right after reset
    tick(1'b0, 8'h00, 1'b1);
    check_eq("uf_rd_err", rd_err, ERR_EN);
    check_eq("uf_rdata", rdata, 0);
    check_eq("uf_empty", empty, 1);
    tick(1'b0, 8'h00, 1'b0);
    check_eq("uf_rd_err_clr", rd_err, 0);

    // 16 writes then 16 reads
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, word(8'h5A, i), 1'b0);
      check_eq("w16_full", full, (i == 15) ? 1 : 0);
      check_eq("w16_empty", empty, 0);
      check_eq("w16_wr_err", wr_err, 0);
    end
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      check_eq("r16_data", rdata, word(8'h5A, i));
      check_eq("r16_empty", empty, (i == 15) ? 1 : 0);
      check_eq("r16_full", full, 0);
      check_eq("r16_rd_err", rd_err, 0);
    end
    tick(1'b0, 8'h00, 1'b0);
    check_eq("r16_rdata_hold", rdata, word(8'h5A, 15));

    // 17 writes: the last one overflows and is dropped
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, word(8'h11, i), 1'b0);
      if (i >= 15) check_eq("w17_full", full, 1);
      check_eq("w17_wr_err", wr_err, (i == 16) ? ERR_EN : 1'b0);
    end
    tick(1'b0, 8'h00, 1'b0);
    check_eq("w17_wr_err_clr", wr_err, 0);
    check_eq("w17_full_hold", full, 1);

    // Concurrent read+write while full: read proceeds, write rejected
    tick(1'b1, 8'hEE, 1'b1);
    check_eq("fullrw_rdata", rdata, word(8'h11, 0));
    check_eq("fullrw_wr_err", wr_err, ERR_EN);
    check_eq("fullrw_full", full, 0);
    for (int i = 1; i < 16; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      check_eq("d17_data", rdata, word(8'h11, i));
      check_eq("d17_wr_err", wr_err, 0);
    end
    check_eq("d17_empty", empty, 1);
    tick(1'b0, 8'h00, 1'b1);
    check_eq("d17_extra_rd_err", rd_err, ERR_EN);
    check_eq("d17_extra_rdata", rdata, word(8'h11, 15));

    // Concurrent read+write while empty: write proceeds, read rejected
    tick(1'b1, 8'hC3, 1'b1);
    check_eq("emptyrw_rd_err", rd_err, ERR_EN);
    check_eq("emptyrw_rdata", rdata, word(8'h11, 15));
    check_eq("emptyrw_empty", empty, 0);
    tick(1'b0, 8'h00, 1'b1);
    check_eq("emptyrw_data", rdata, 8'hC3);
    check_eq("emptyrw_rd_err_clr", rd_err, 0);
    check_eq("emptyrw_empty2", empty, 1);

    // 11 writes then 11 reads
    for (int i = 0; i < 11; i++) begin
      tick(1'b1, word(8'h33, i), 1'b0);
      check_eq("w11_full", full, 0);
    end
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      check_eq("r11_data", rdata, word(8'h33, i));
      check_eq("r11_full", full, 0);
    end
    check_eq("r11_empty", empty, 1);

    // Overlapped stream: reads start one cycle after writes
    tick(1'b1, word(8'h71, 0), 1'b0);
    check_eq("ov_empty0", empty, 0);
    for (int i = 1; i < 16; i++) begin
      tick(1'b1, word(8'h71, i), 1'b1);
      check_eq("ov_data", rdata, word(8'h71, i - 1));
      check_eq("ov_empty", empty, 0);
      check_eq("ov_rd_err", rd_err, 0);
      check_eq("ov_full", full, 0);
    end
    tick(1'b0, 8'h00, 1'b1);
    check_eq("ov_data_last", rdata, word(8'h71, 15));
    check_eq("ov_empty_end", empty, 1);
    check_eq("ov_rd_err_end", rd_err, 0);

    // Reset mid-stream overrides concurrent requests
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'hB6, 1'b0);
    tick(1'b1, 8'hC7, 1'b1);
    check_eq("mid_pre_rdata", rdata, 8'hA5);
    rst = 1'b1;
    tick(1'b1, 8'hD8, 1'b1);
    rst = 1'b0;
    check_eq("mid_rst_empty", empty, 1);
    check_eq("mid_rst_full", full, 0);
    check_eq("mid_rst_rdata", rdata, 0);
    check_eq("mid_rst_wr_err", wr_err, 0);
    check_eq("mid_rst_rd_err", rd_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
